// File: rtl/wb_accel_bridge.sv
// rtl/wb_accel_bridge.sv - Wishbone slave decoupling a val/rdy accelerator through request/response FIFOs
module wb_accel_bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [7:0]       o_count,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered count, so a push into a full FIFO is dropped even alongside a pop
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = 8'(r_count);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & !o_full;
  assign w_pop   = i_pop & !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

module wb_accel_bridge #(
  parameter int          W          = 16,
  parameter int          REQ_DEPTH  = 4,
  parameter int          RESP_DEPTH = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [2*W-1:0] acc_req_msg,
  output logic           acc_req_val,
  input  logic           acc_req_rdy,
  input  logic [W-1:0]   acc_resp_msg,
  input  logic           acc_resp_val,
  output logic           acc_resp_rdy,
  output logic           irq_o
);
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_ovf;
  logic        r_unf;
  logic        r_irq_en;

  logic         w_accept;
  logic [1:0]   w_idx;
  logic         w_wr_req;
  logic         w_rd_resp;
  logic         w_wr_stat;
  logic         w_wr_ctrl;
  logic         w_flush;
  logic         w_req_empty;
  logic         w_req_full;
  logic [7:0]   w_req_count;
  logic         w_resp_empty;
  logic         w_resp_full;
  logic [7:0]   w_resp_count;
  logic [W-1:0] w_resp_head;
  logic [31:0]  w_status;
  logic [31:0]  w_rd_data;
  logic         w_unused;

  assign w_accept  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & !r_ack;
  assign w_idx     = wbs_adr_i[3:2];
  assign w_wr_req  = w_accept & wbs_we_i & (w_idx == 2'd0);
  assign w_rd_resp = w_accept & !wbs_we_i & (w_idx == 2'd1);
  assign w_wr_stat = w_accept & wbs_we_i & (w_idx == 2'd2);
  assign w_wr_ctrl = w_accept & wbs_we_i & (w_idx == 2'd3);
  assign w_flush   = w_wr_ctrl & wbs_dat_i[1];
  assign w_unused  = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  wb_accel_bridge_fifo #(.WIDTH(2*W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (w_flush),
    .i_push  (w_wr_req),
    .i_data  (wbs_dat_i[2*W-1:0]),
    .i_pop   (acc_req_val & acc_req_rdy),
    .o_data  (acc_req_msg),
    .o_count (w_req_count),
    .o_empty (w_req_empty),
    .o_full  (w_req_full)
  );

  wb_accel_bridge_fifo #(.WIDTH(W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (w_flush),
    .i_push  (acc_resp_val & acc_resp_rdy),
    .i_data  (acc_resp_msg),
    .i_pop   (w_rd_resp),
    .o_data  (w_resp_head),
    .o_count (w_resp_count),
    .o_empty (w_resp_empty),
    .o_full  (w_resp_full)
  );

  assign acc_req_val  = !w_req_empty;
  assign acc_resp_rdy = wb_rst_ni & !w_resp_full;
  assign irq_o        = r_irq_en & ((w_resp_count != 8'd0) | r_ovf | r_unf);
  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;

  assign w_status = {8'd0, w_resp_count, w_req_count, 2'b00, r_unf, r_ovf,
                     w_resp_full, w_resp_empty, w_req_full, w_req_empty};

  always_comb begin
    w_rd_data = '0;
    if (!wbs_we_i) begin
      case (w_idx)
        2'd1:    w_rd_data = w_resp_empty ? 32'd0 : 32'(w_resp_head);
        2'd2:    w_rd_data = w_status;
        2'd3:    w_rd_data = {31'd0, r_irq_en};
        default: w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_dat <= w_accept ? w_rd_data : 32'd0;
      if (w_wr_ctrl) r_irq_en <= wbs_dat_i[0];
      if (w_flush) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (w_wr_stat && wbs_dat_i[4]) r_ovf <= 1'b0;
        if (w_wr_stat && wbs_dat_i[5]) r_unf <= 1'b0;
        if (w_wr_req && w_req_full)    r_ovf <= 1'b1;
        if (w_rd_resp && w_resp_empty) r_unf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_accel_bridge.sv
// tb/tb_wb_accel_bridge.sv - scoreboard bench for wb_accel_bridge
module tb_wb_accel_bridge;
  localparam int W = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'hF;
  logic [31:0]   adr = '0, dat_i = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [2*W-1:0] req_msg;
  logic          req_val;
  logic          req_rdy = 1'b0;
  logic [W-1:0]  resp_msg = '0;
  logic          resp_val = 1'b0;
  logic          resp_rdy;
  logic          irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] acc_q[$];

  wb_accel_bridge #(.W(W), .REQ_DEPTH(4), .RESP_DEPTH(4), .ADDR_BASE(BASE)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_i),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .acc_req_msg  (req_msg),
    .acc_req_val  (req_val),
    .acc_req_rdy  (req_rdy),
    .acc_resp_msg (resp_msg),
    .acc_resp_val (resp_val),
    .acc_resp_rdy (resp_rdy),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wishbone read-data scoreboard
  always @(negedge clk) begin
    if (ack) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        if (e.chk) check(e.name, dat_o, e.exp);
      end
    end
  end

  // Accelerator request scoreboard
  always @(negedge clk) begin
    if (rst_n && req_val && req_rdy) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got msg=%h expected none", req_msg);
      end else begin
        logic [31:0] e;
        e = acc_q.pop_front();
        check("acc_req_msg", req_msg, e);
      end
    end
  end

  task automatic wb_access(input bit w, input logic [1:0] idx, input logic [31:0] d,
                           input bit chk, input logic [31:0] exp, input string name);
    wb_exp_t e;
    bit got = 0;
    e.chk = chk; e.exp = exp; e.name = name;
    wb_q.push_back(e);
    cyc = 1; stb = 1; we = w; adr = BASE | {28'd0, idx, 2'b00}; dat_i = d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack expected ack", name);
      void'(wb_q.pop_back());
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
    wb_access(1'b1, idx, d, 1'b0, 32'd0, "write");
  endtask

  task automatic wb_read(input logic [1:0] idx, input logic [31:0] exp, input string name);
    wb_access(1'b0, idx, 32'd0, 1'b1, exp, name);
  endtask

  task automatic send_results(input int n, input logic [W-1:0] base, output int sent);
    bit cap;
    sent = 0;
    resp_val = 1;
    for (int i = 0; i < n; i++) begin
      resp_msg = base + W'(i);
      cap = resp_rdy;
      @(posedge clk); #1;
      if (cap) sent++;
    end
    resp_val = 0;
  endtask

  initial begin
    int sent;
    int acks;

    #2;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_req_val", {31'd0, req_val}, 32'd0);
    check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_resp_rdy", {31'd0, resp_rdy}, 32'd1);
    wb_read(2'd2, 32'h0000_0005, "status_reset");

    // Unmatched address never acks
    acks = 0;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    check("unmatched_no_ack", acks, 0);

    // Basic request / response round trip
    wb_write(2'd0, 32'h000F_0005);
    check("req_val_after_write", {31'd0, req_val}, 32'd1);
    check("req_msg_after_write", req_msg, 32'h000F_0005);
    acc_q.push_back(32'h000F_0005);
    req_rdy = 1;
    @(posedge clk); #1 req_rdy = 0;
    check("req_val_after_pop", {31'd0, req_val}, 32'd0);
    send_results(1, 16'd5, sent);
    check("sent_one", sent, 1);
    wb_read(2'd1, 32'h0000_0005, "resp_gcd");
    wb_read(2'd2, 32'h0000_0005, "status_resp_empty");

    // Request overflow
    for (int i = 1; i <= 5; i++) wb_write(2'd0, 32'h0001_0001 * i);
    wb_read(2'd2, 32'h0000_0416, "status_ovf");
    wb_write(2'd2, 32'h0000_0010);
    wb_read(2'd2, 32'h0000_0406, "status_ovf_cleared");
    for (int i = 1; i <= 4; i++) acc_q.push_back(32'h0001_0001 * i);
    req_rdy = 1;
    repeat (5) @(posedge clk);
    #1 req_rdy = 0;
    check("req_drained", {31'd0, req_val}, 32'd0);

    // Underflow and interrupt
    wb_read(2'd1, 32'h0000_0000, "resp_underflow");
    wb_read(2'd2, 32'h0000_0025, "status_unf");
    check("irq_masked", {31'd0, irq}, 32'd0);
    wb_write(2'd3, 32'h0000_0001);
    check("irq_unf", {31'd0, irq}, 32'd1);
    wb_read(2'd3, 32'h0000_0001, "ctrl_read");
    wb_write(2'd2, 32'h0000_0020);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wb_read(2'd2, 32'h0000_0005, "status_unf_cleared");

    // Response FIFO fills, backpressure, ordering and wrap
    req_rdy = 1;
    send_results(6, 16'h0100, sent);
    check("resp_sent_full", sent, 4);
    check("resp_rdy_full", {31'd0, resp_rdy}, 32'd0);
    check("irq_resp", {31'd0, irq}, 32'd1);
    wb_read(2'd2, 32'h0004_0009, "status_resp_full");
    for (int i = 0; i < 4; i++) wb_read(2'd1, 32'h0000_0100 + i, "resp_order");
    wb_read(2'd2, 32'h0000_0005, "status_resp_drained");
    check("irq_resp_drained", {31'd0, irq}, 32'd0);
    send_results(4, 16'h0200, sent);
    check("resp_sent_wrap", sent, 4);
    for (int i = 0; i < 4; i++) wb_read(2'd1, 32'h0000_0200 + i, "resp_wrap");
    req_rdy = 0;

    // Flush with a same-cycle accelerator push
    wb_read(2'd1, 32'h0000_0000, "resp_underflow2");
    wb_write(2'd0, 32'h0000_1111);
    wb_write(2'd0, 32'h0000_2222);
    send_results(2, 16'h0300, sent);
    wb_read(2'd2, 32'h0002_0220, "status_pre_flush");
    resp_val = 1; resp_msg = 16'h0399;
    wb_write(2'd3, 32'h0000_0002);
    resp_val = 0;
    wb_read(2'd2, 32'h0000_0005, "status_post_flush");
    check("req_val_post_flush", {31'd0, req_val}, 32'd0);
    wb_read(2'd3, 32'h0000_0000, "ctrl_post_flush");

    // Reset in the middle of a transfer
    wb_write(2'd3, 32'h0000_0001);
    wb_write(2'd0, 32'h0007_0003);
    send_results(1, 16'h0400, sent);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_req_val", {31'd0, req_val}, 32'd1);
    cyc = 1; stb = 1; we = 0; adr = BASE | 32'h4;
    #2 rst_n = 0;
    #1;
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_req_val", {31'd0, req_val}, 32'd0);
    check("mid_rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 cyc = 0; stb = 0;
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_no_ack", {31'd0, ack}, 32'd0);
    wb_read(2'd2, 32'h0000_0005, "status_after_rst");
    wb_read(2'd3, 32'h0000_0000, "ctrl_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("wb_q_empty", wb_q.size(), 0);
    check("acc_q_empty", acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
